// File: rtl/dma_frame_scheduler.sv
// dma_frame_scheduler: sequences ping-pong read+write DMA frames with response checking and a per-frame watchdog
module dma_frame_scheduler #(
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int TIMEOUT_LOG    = 21
) (
   input  logic        m_axi_acp_aclk,
   input  logic        axi_reset,
   input  logic        cfg_start,
   input  logic        cfg_stop,
   input  logic        cfg_continuous,
   input  logic [15:0] cfg_frame_count,
   input  logic [31:0] cfg_src_base,
   input  logic [31:0] cfg_dst_base,
   input  logic [31:0] cfg_stride,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frames_done,
   output logic        buf_index,
   output logic        error,
   output logic [1:0]  error_code,
   output logic        read_active,
   output logic [31:0] read_address,
   input  logic        read_idle,
   output logic        write_active,
   output logic [31:0] write_address,
   input  logic        write_idle,
   input  logic [3:0]  rw_resp
);
   localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, RUN, ERR} state_t;
   state_t state, state_nxt;
   logic [SW-1:0] settle_cnt;
   logic [TIMEOUT_LOG-1:0] wdog;
   logic [31:0] src_base, dst_base, stride, offset;
   logic [15:0] frame_count;
   logic continuous, stop_pending;
   logic start_ok, bad_resp, frame_end, timeout, last_frame;
   always_ff @(posedge m_axi_acp_aclk) begin
      if (axi_reset) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      start_ok = cfg_start && (state == IDLE || state == ERR) && (cfg_continuous || cfg_frame_count != 16'd0);
      bad_resp = rw_resp[3] || rw_resp[1];
      frame_end = state == RUN && read_idle && write_idle;
      timeout = state == RUN && !frame_end && wdog == TIMEOUT_LOG'(TIMEOUT_CYCLES - 1);
      last_frame = !continuous && frames_done + 16'd1 == frame_count;
      busy = state == LAUNCH || state == SETTLE || state == RUN;
      error = state == ERR;
      read_active = state == LAUNCH;
      write_active = state == LAUNCH;
      frame_done = frame_end;
      offset = buf_index ? stride : 32'd0;
      read_address = read_active ? src_base + offset : 32'd0;
      write_address = write_active ? dst_base + offset : 32'd0;
      state_nxt = state;
      case (state)
         IDLE, ERR: state_nxt = start_ok ? LAUNCH : state;
         LAUNCH:    state_nxt = SETTLE;
         SETTLE:    state_nxt = settle_cnt == SW'(SETTLE_CYCLES - 1) ? RUN : SETTLE;
         RUN:       state_nxt = frame_end ? ((error_code[0] || bad_resp) ? ERR :
                                             (stop_pending || cfg_stop || last_frame) ? IDLE : LAUNCH) :
                                timeout ? ERR : RUN;
         default:   state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge m_axi_acp_aclk) begin
      if (axi_reset) begin
         src_base <= '0;
         dst_base <= '0;
         stride <= '0;
         frame_count <= '0;
         continuous <= 1'b0;
         stop_pending <= 1'b0;
         frames_done <= '0;
         buf_index <= 1'b0;
         error_code <= '0;
         settle_cnt <= '0;
         wdog <= '0;
      end else begin
         if (start_ok) begin
            src_base <= cfg_src_base;
            dst_base <= cfg_dst_base;
            stride <= cfg_stride;
            frame_count <= cfg_frame_count;
            continuous <= cfg_continuous;
            stop_pending <= 1'b0;
            frames_done <= '0;
            buf_index <= 1'b0;
            error_code <= '0;
         end else begin
            if (busy && cfg_stop) stop_pending <= 1'b1;
            if (state == RUN && bad_resp) error_code[0] <= 1'b1;
            if (timeout) error_code[1] <= 1'b1;
            if (frame_end) begin
               frames_done <= frames_done + 16'd1;
               buf_index <= ~buf_index;
            end
         end
         settle_cnt <= state == SETTLE ? settle_cnt + 1'b1 : '0;
         wdog <= state == RUN ? wdog + 1'b1 : '0;
      end
   end
endmodule

// File: tb/tb_dma_frame_scheduler.sv
// tb_dma_frame_scheduler: scoreboard bench with a DMA channel model and frame-level reference model
module tb_dma_frame_scheduler;
   localparam int ST = 2;
   localparam int TO = 50;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic axi_reset, cfg_start, cfg_stop, cfg_continuous;
   logic [15:0] cfg_frame_count;
   logic [31:0] cfg_src_base, cfg_dst_base, cfg_stride;
   logic busy, frame_done, buf_index, error, read_active, write_active, read_idle, write_idle;
   logic [15:0] frames_done;
   logic [1:0] error_code;
   logic [31:0] read_address, write_address;
   logic [3:0] rw_resp, err_val, okv;
   int tests = 0, fails = 0;
   int rcnt = 0, wcnt = 0, launches = 0, err_at = -1;
   logic hang = 1'b0;
   typedef struct {logic [31:0] ra; logic [31:0] wa;} launch_t;
   launch_t launch_q[$];
   int done_q[$];

   dma_frame_scheduler #(.SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO), .TIMEOUT_LOG(6)) dut (
      .m_axi_acp_aclk(clk), .axi_reset(axi_reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_continuous(cfg_continuous), .cfg_frame_count(cfg_frame_count), .cfg_src_base(cfg_src_base),
      .cfg_dst_base(cfg_dst_base), .cfg_stride(cfg_stride), .busy(busy), .frame_done(frame_done),
      .frames_done(frames_done), .buf_index(buf_index), .error(error), .error_code(error_code),
      .read_active(read_active), .read_address(read_address), .read_idle(read_idle),
      .write_active(write_active), .write_address(write_address), .write_idle(write_idle), .rw_resp(rw_resp)
   );

   // DMA model: each launch keeps a channel busy for a random 3..40 cycles
   always @(posedge clk) begin
      okv <= {1'b0, 1'($urandom), 1'b0, 1'($urandom)};
      if (read_active) begin
         rcnt <= $urandom_range(3, 40);
         wcnt <= $urandom_range(3, 40);
         launches <= launches + 1;
      end else begin
         if (rcnt > 0) rcnt <= rcnt - 1;
         if (wcnt > 0) wcnt <= wcnt - 1;
      end
   end
   assign read_idle = rcnt == 0 && !hang;
   assign write_idle = wcnt == 0 && !hang;
   assign rw_resp = (rcnt == 1 && launches == err_at) ? err_val : okv;

   task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, got, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      launch_t e;
      int i;
      if (read_active || write_active) begin
         if (launch_q.size() == 0) check("unexpected_launch", read_address, 32'hxxxx_xxxx);
         else begin
            e = launch_q.pop_front();
            check("launch_pair", {31'd0, read_active && write_active}, 32'd1);
            check("read_address", read_address, e.ra);
            check("write_address", write_address, e.wa);
         end
      end
      if (frame_done) begin
         if (done_q.size() == 0) check("unexpected_frame_done", 32'(frames_done), 32'hxxxx_xxxx);
         else begin
            i = done_q.pop_front();
            check("frames_done_at_pulse", 32'(frames_done), 32'(i));
            check("buf_index_at_pulse", 32'(buf_index), 32'(i & 1));
         end
      end
   end

   task automatic start_pulse(input logic cont, input logic [15:0] cnt, input logic [31:0] src, dst, str);
      cfg_continuous = cont;
      cfg_frame_count = cnt;
      cfg_src_base = src;
      cfg_dst_base = dst;
      cfg_stride = str;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic expect_frames(input int n, input logic [31:0] src, dst, str);
      launch_t e;
      for (int i = 0; i < n; i++) begin
         e.ra = src + ((i % 2) ? str : 32'd0);
         e.wa = dst + ((i % 2) ? str : 32'd0);
         launch_q.push_back(e);
         done_q.push_back(i);
      end
   endtask

   task automatic wait_launch(input int tgt);
      int k;
      for (k = 0; k < 3000; k++) begin
         if (read_active && launches == tgt) break;
         @(negedge clk);
      end
      if (k == 3000) check("wait_launch_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 3000; k++) begin
         if (!busy) break;
         @(negedge clk);
      end
      if (k == 3000) check("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   // stop_mode: 0 none, 1 stop during frame s, 2 stop on the frame-end cycle of frame s; e: resp error in frame e
   task automatic run(input logic cont, input logic [15:0] cnt, input logic [31:0] src, dst, str,
                      input int stop_mode, input int s, input int e);
      int n, base;
      n = e > 0 ? e : (stop_mode > 0 ? s : int'(cnt));
      expect_frames(n, src, dst, str);
      base = launches;
      err_at = e > 0 ? base + e : -1;
      err_val = 4'($urandom_range(0, 3));
      err_val = err_val == 0 ? 4'b1000 : err_val == 1 ? 4'b1100 : err_val == 2 ? 4'b0010 : 4'b0011;
      start_pulse(cont, cnt, src, dst, str);
      check("start_busy", 32'(busy), 32'd1);
      check("start_error_code", {29'd0, error, error_code}, 32'd0);
      check("start_frames_done", 32'(frames_done), 32'd0);
      start_pulse(1'($urandom), 16'($urandom), $urandom, $urandom, $urandom);
      if (stop_mode == 1) begin
         if (s > 1) begin
            wait_launch(base + s - 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         cfg_stop = 1'b1;
         @(negedge clk);
         cfg_stop = 1'b0;
      end else if (stop_mode == 2) begin
         for (int k = 0; k < 3000 && !(frame_done && frames_done == 16'(s - 1)); k++) @(negedge clk);
         cfg_stop = 1'b1;
         @(negedge clk);
         cfg_stop = 1'b0;
      end
      wait_idle();
      check("end_error", 32'(error), 32'(e > 0));
      check("end_error_code", 32'(error_code), e > 0 ? 32'd1 : 32'd0);
      check("end_frames_done", 32'(frames_done), 32'(n));
      check("end_buf_index", 32'(buf_index), 32'(n & 1));
      repeat (8) @(negedge clk);
      check("stays_idle", 32'(busy), 32'd0);
      check("queues_drained", 32'(launch_q.size() + done_q.size()), 32'd0);
      err_at = -1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      int k, base, cnt, mode, s;
      logic cont;
      axi_reset = 1'b1;
      cfg_start = 1'b0;
      cfg_stop = 1'b0;
      cfg_continuous = 1'b0;
      cfg_frame_count = '0;
      cfg_src_base = '0;
      cfg_dst_base = '0;
      cfg_stride = '0;
      repeat (3) @(negedge clk);
      check("reset_flags", {25'd0, busy, frame_done, buf_index, error, error_code, read_active, write_active}, 32'd0);
      check("reset_frames_done", 32'(frames_done), 32'd0);
      axi_reset = 1'b0;
      @(negedge clk);
      run(1'b0, 16'd3, 32'h1000_0000, 32'h2000_0000, 32'h0030_0000, 0, 0, 0);
      run(1'b1, 16'd0, 32'h1000_0000, 32'h2000_0000, 32'h0030_0000, 1, 2, 0);
      run(1'b0, 16'd4, 32'h1234_0000, 32'h5678_0000, 32'h0010_0000, 0, 0, 1);
      run(1'b0, 16'd2, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h0000_0200, 0, 0, 0);
      // watchdog: idle held low from the start
      hang = 1'b1;
      expect_frames(1, 32'hA000_0000, 32'hB000_0000, 32'h100);
      void'(done_q.pop_back());
      start_pulse(1'b0, 16'd2, 32'hA000_0000, 32'hB000_0000, 32'h100);
      for (k = 1; k < 200; k++) begin
         @(negedge clk);
         if (error) break;
      end
      check("timeout_latency", 32'(k), 32'(ST + 1 + TO));
      check("timeout_code", 32'(error_code), 32'd2);
      check("timeout_frames_done", {15'd0, busy, frames_done}, 32'd0);
      hang = 1'b0;
      // reset in RUN of frame 2
      expect_frames(2, 32'h0100_0000, 32'h0200_0000, 32'h40);
      void'(done_q.pop_back());
      base = launches;
      start_pulse(1'b1, 16'd0, 32'h0100_0000, 32'h0200_0000, 32'h40);
      wait_launch(base + 1);
      repeat (3) @(negedge clk);
      axi_reset = 1'b1;
      @(negedge clk);
      check("rst_run_flags", {25'd0, busy, frame_done, buf_index, error, error_code, read_active, write_active}, 32'd0);
      check("rst_run_frames_done", 32'(frames_done), 32'd0);
      check("rst_run_addr", read_address | write_address, 32'd0);
      axi_reset = 1'b0;
      start_pulse(1'b0, 16'd0, 32'h0300_0000, 32'h0400_0000, 32'h40);
      repeat (10) @(negedge clk);
      check("zero_count_ignored", 32'(busy), 32'd0);
      check("rst_queues_drained", 32'(launch_q.size() + done_q.size()), 32'd0);
      run(1'b1, 16'd0, 32'h0800_0000, 32'h0900_0000, 32'h0001_0000, 2, 2, 0);
      run(1'b0, 16'd5, 32'h0800_0000, 32'h0900_0000, 32'h0001_0000, 2, 3, 0);
      for (int r = 0; r < 8; r++) begin
         cont = 1'($urandom);
         cnt = $urandom_range(1, 5);
         mode = $urandom_range(0, 3);
         if (cont && mode == 0) mode = 1;
         s = $urandom_range(1, cont ? 4 : cnt);
         run(cont, 16'(cnt), $urandom, $urandom, $urandom, mode == 3 ? 0 : mode, s, mode == 3 ? s : 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
